vect_issue_ctrl: RTL and testbench
==================================

VECT_ISSUE_CTRL -- requirements
Module: vect_issue_ctrl

Interface
REQ-001 SHALL have parameter INSTR_WIDTH, default 32, instruction word width.
REQ-002 SHALL have parameter LANES, default 4, number of vector lanes; power of 2, at least 2.
REQ-003 SHALL have parameter VLMAX, default 32, maximum vector length; a multiple of LANES, at most 63.
REQ-004 SHALL have ports: clk_i  in  1  clock, single domain; all state updates on its rising edge.
REQ-005 SHALL have ports: rst_i  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports: instr_i  in  INSTR_WIDTH  head word of the issue FIFO; first-word-fall-through, valid whenever buf_empty_i=0.
REQ-007 SHALL have ports: buf_empty_i  in  1  issue FIFO empty.
REQ-008 SHALL have ports: buf_read_o  out  1  one-cycle FIFO pop strobe.
REQ-009 SHALL have ports: lane_ready_i  in  1  lanes accept the current element group.
REQ-010 SHALL have ports: flush_i  in  1  synchronous abort of the instruction in flight.
REQ-011 SHALL have ports: issue_valid_o  out  1  element group valid to lanes.
REQ-012 SHALL have ports: instr_o  out  INSTR_WIDTH  latched instruction being issued.
REQ-013 SHALL have ports: lane_en_o  out  LANES  per-lane element enable.
REQ-014 SHALL have ports: elem_base_o  out  6  index of lane 0's element in the current group.
REQ-015 SHALL have ports: last_o  out  1  current group is the final group.
REQ-016 SHALL have ports: vl_o  out  6  current vector length.
REQ-017 SHALL have ports: busy_o  out  1  controller not in IDLE.

Function
REQ-018 SHALL implement states IDLE and ISSUE; busy_o=1 exactly in ISSUE.
REQ-019 IDLE with buf_empty_i=0 and flush_i=0: SHALL assert buf_read_o for that cycle and decode instr_i.
REQ-020 A word with instr_i[31]=1 is a config: vl SHALL become min(instr_i[25:20], VLMAX) next cycle, and the state SHALL stay IDLE.
REQ-021 A word with instr_i[31]=0 and vl=0 SHALL be popped and discarded; there is no issue, and the state stays IDLE.
REQ-022 A word with instr_i[31]=0 and vl>0 SHALL be latched into instr_o, the group counter SHALL be set to 0, and the state SHALL go to ISSUE next cycle.
REQ-023 In ISSUE, issue_valid_o SHALL be 1.
REQ-024 In ISSUE, elem_base_o SHALL equal group*LANES.
REQ-025 In ISSUE, lane_en_o[i] SHALL be 1 iff elem_base_o+i < vl.
REQ-026 In ISSUE, last_o SHALL be 1 iff elem_base_o+LANES >= vl.
REQ-027 A group transfers when issue_valid_o=1 and lane_ready_i=1; while lane_ready_i=0, all issue outputs SHALL hold stable.
REQ-028 On transfer of a non-last group, the group counter SHALL increment.
REQ-029 On transfer of the last group, the state SHALL return to IDLE; the next pop is no earlier than the following cycle.
REQ-030 An instruction SHALL take ceil(vl/LANES) ISSUE cycles with lane_ready_i held 1, plus the 1 IDLE pop cycle.
REQ-031 buf_read_o SHALL never assert in ISSUE or when buf_empty_i=1.
REQ-032 flush_i=1 SHALL have priority over pop and transfer: no pop that cycle, the state goes to IDLE next cycle, and vl is retained.
REQ-033 flush_i=1 in IDLE SHALL be a no-op apart from suppressing the pop.
REQ-034 Outside ISSUE, issue_valid_o, lane_en_o, elem_base_o and last_o SHALL be 0; instr_o SHALL hold its last value.

Reset
REQ-035 rst_i=1 SHALL immediately force: state IDLE, vl_o=0, group counter 0, instr_o=0, all strobes and enables 0.
REQ-036 Reset SHALL take effect at any time, including mid-ISSUE; no FIFO pop occurs while rst_i=1.
REQ-037 After rst_i deasserts, operation SHALL resume at the first rising edge.

Verification
REQ-038 Bench SHALL cover: reset, then op word in FIFO -> one buf_read_o pulse, word discarded, issue_valid_o never 1, vl_o=0.
REQ-039 Bench SHALL cover: config 10 then op, LANES=4, ready held 1 -> 3 ISSUE cycles with elem_base 0/4/8 and lane_en 1111/1111/0011; last_o on the third cycle only.
REQ-040 Bench SHALL cover: same op with lane_ready_i=0 for 2 cycles during group 1 -> elem_base_o=4 and instr_o held; 5 ISSUE cycles total.
REQ-041 Bench SHALL cover: config request 40 with VLMAX=32 -> vl_o=32; following op issues 8 groups.
REQ-042 Bench SHALL cover: flush_i during group 1 with FIFO non-empty -> IDLE next cycle, no pop in the flush cycle, next op starts at group 0 with vl unchanged.
REQ-043 Bench SHALL cover: rst_i asserted mid-ISSUE -> outputs 0 in the same cycle, vl_o=0, no pop until rst_i deasserts.

Source files
------------

// File: rtl/vect_issue_ctrl.sv
// Vector issue controller: pops instruction words from a first-word-fall-through
// FIFO, handles vector-length configuration words, and issues each vector
// operation to the lanes as a series of LANES-wide element groups.
//
// Ports:
//   clk_i          clock, all state updates on the rising edge
//   rst_i          asynchronous active-high reset
//   instr_i        FIFO head word (valid while buf_empty_i=0)
//   buf_empty_i    FIFO empty
//   buf_read_o     one-cycle FIFO pop strobe (combinational from state/inputs)
//   lane_ready_i   lanes accept the current element group
//   flush_i        synchronous abort of the instruction in flight
//   issue_valid_o  element group valid to lanes
//   instr_o        latched instruction being issued
//   lane_en_o      per-lane element enable
//   elem_base_o    element index of lane 0 in the current group
//   last_o         current group is the final group
//   vl_o           current vector length
//   busy_o         controller in ISSUE
module vect_issue_ctrl #(
    parameter int unsigned INSTR_WIDTH = 32,
    parameter int unsigned LANES       = 4,
    parameter int unsigned VLMAX       = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [INSTR_WIDTH-1:0] instr_i,
    input  logic                   buf_empty_i,
    output logic                   buf_read_o,
    input  logic                   lane_ready_i,
    input  logic                   flush_i,
    output logic                   issue_valid_o,
    output logic [INSTR_WIDTH-1:0] instr_o,
    output logic [LANES-1:0]       lane_en_o,
    output logic [5:0]             elem_base_o,
    output logic                   last_o,
    output logic [5:0]             vl_o,
    output logic                   busy_o
);

    localparam int unsigned LANE_SHIFT = $clog2(LANES);
    localparam logic [5:0]  VLMAX_W    = 6'(VLMAX);
    localparam logic [6:0]  LANES_W    = 7'(LANES);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t                 state;
    logic [5:0]             vl;
    logic [5:0]             group;
    logic [INSTR_WIDTH-1:0] instr;

    logic                   in_issue_c;
    logic                   pop_c;
    logic                   is_cfg_c;
    logic [5:0]             cfg_vl_c;
    logic [5:0]             base_c;
    logic                   last_c;
    logic [LANES-1:0]       lane_en_c;

    // Pop only from IDLE; flush and reset both suppress it.
    assign in_issue_c = (state == ISSUE);
    assign pop_c      = !in_issue_c && !buf_empty_i && !flush_i && !rst_i;
    assign is_cfg_c   = instr_i[31];
    assign cfg_vl_c   = (instr_i[25:20] > VLMAX_W) ? VLMAX_W : instr_i[25:20];

    // Group geometry; 7-bit sums so base+LANES cannot wrap.
    assign base_c = 6'(group << LANE_SHIFT);
    assign last_c = (7'(base_c) + LANES_W) >= 7'(vl);

    always_comb begin
        lane_en_c = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            lane_en_c[i] = (7'(base_c) + 7'(i)) < 7'(vl);
        end
    end

    // Controller state: decode on pop, walk groups while issuing.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            vl    <= '0;
            group <= '0;
            instr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop_c) begin
                        if (is_cfg_c) begin
                            vl <= cfg_vl_c;
                        end else if (vl != 6'd0) begin
                            instr <= instr_i;
                            group <= '0;
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (flush_i) begin
                        state <= IDLE;
                    end else if (lane_ready_i) begin
                        if (last_c) begin
                            state <= IDLE;
                        end else begin
                            group <= group + 6'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Issue outputs are decoded from registers and forced to zero outside ISSUE.
    assign buf_read_o    = pop_c;
    assign issue_valid_o = in_issue_c;
    assign busy_o        = in_issue_c;
    assign elem_base_o   = in_issue_c ? base_c : 6'd0;
    assign lane_en_o     = in_issue_c ? lane_en_c : '0;
    assign last_o        = in_issue_c && last_c;
    assign vl_o          = vl;
    assign instr_o       = instr;

endmodule

// File: tb/tb_vect_issue_ctrl.sv
module tb_vect_issue_ctrl;

    localparam int unsigned IW    = 32;
    localparam int unsigned LANES = 4;
    localparam int unsigned VLMAX = 32;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b0;
    logic [IW-1:0]   instr_i = '0;
    logic            buf_empty_i = 1'b1;
    logic            buf_read_o;
    logic            lane_ready_i = 1'b1;
    logic            flush_i = 1'b0;
    logic            issue_valid_o;
    logic [IW-1:0]   instr_o;
    logic [LANES-1:0] lane_en_o;
    logic [5:0]      elem_base_o;
    logic            last_o;
    logic [5:0]      vl_o;
    logic            busy_o;

    vect_issue_ctrl #(.INSTR_WIDTH(IW), .LANES(LANES), .VLMAX(VLMAX)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .instr_i      (instr_i),
        .buf_empty_i  (buf_empty_i),
        .buf_read_o   (buf_read_o),
        .lane_ready_i (lane_ready_i),
        .flush_i      (flush_i),
        .issue_valid_o(issue_valid_o),
        .instr_o      (instr_o),
        .lane_en_o    (lane_en_o),
        .elem_base_o  (elem_base_o),
        .last_o       (last_o),
        .vl_o         (vl_o),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [5:0]       base;
        logic [LANES-1:0] en;
        logic             last;
        logic [IW-1:0]    instr;
    } grp_t;

    grp_t          sb[$];
    logic [IW-1:0] fifo[$];
    int            total = 0;
    int            bad   = 0;
    int            pops  = 0;
    int            ivc   = 0;
    int            model_vl = 0;
    int            p0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void refresh();
        buf_empty_i = (fifo.size() == 0);
        instr_i     = (fifo.size() == 0) ? '0 : fifo[0];
    endfunction

    function automatic logic [IW-1:0] cfg_word(input int v);
        return 32'h8000_0000 | (32'(v & 63) << 20);
    endfunction

    // Config word: bench vector-length model follows it.
    task automatic push_cfg(input int v);
        fifo.push_back(cfg_word(v));
        model_vl = (v > int'(VLMAX)) ? int'(VLMAX) : v;
        refresh();
    endtask

    // Op word: expected groups go to the scoreboard for the current vl.
    task automatic push_op(input logic [IW-1:0] w, input bit expect_groups);
        grp_t g;
        fifo.push_back(w);
        if (expect_groups) begin
            for (int b = 0; b < model_vl; b += int'(LANES)) begin
                g.base  = 6'(b);
                g.instr = w;
                g.last  = (b + int'(LANES)) >= model_vl;
                for (int i = 0; i < int'(LANES); i++) g.en[i] = (b + i) < model_vl;
                sb.push_back(g);
            end
        end
        refresh();
    endtask

    // One cycle: observe at negedge, then advance FIFO model after the edge.
    task automatic tick();
        bit rd;
        grp_t g;
        @(negedge clk_i);
        rd = buf_read_o;
        if (rd) begin
            pops++;
            chk("pop_in_issue", 64'(issue_valid_o), 64'd0);
            chk("pop_when_empty", 64'(buf_empty_i), 64'd0);
        end
        if (issue_valid_o) begin
            ivc++;
            if (sb.size() == 0) begin
                chk("unexpected_issue", 64'(issue_valid_o), 64'd0);
            end else begin
                g = sb[0];
                chk("elem_base", 64'(elem_base_o), 64'(g.base));
                chk("lane_en", 64'(lane_en_o), 64'(g.en));
                chk("last", 64'(last_o), 64'(g.last));
                chk("instr", 64'(instr_o), 64'(g.instr));
                chk("busy", 64'(busy_o), 64'd1);
                if (lane_ready_i && !flush_i && !rst_i) void'(sb.pop_front());
            end
        end else begin
            chk("idle_outputs", {elem_base_o, lane_en_o, last_o, busy_o}, 64'd0);
        end
        @(posedge clk_i);
        #1;
        if (rd) void'(fifo.pop_front());
        refresh();
    endtask

    task automatic run_until_idle(input int budget);
        int n = 0;
        while ((sb.size() != 0 || fifo.size() != 0 || busy_o) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) chk("timeout", 64'd0, 64'd1);
    endtask

    initial begin
        refresh();
        #1 rst_i = 1'b1;
        #1;
        // Reset state.
        chk("rst_outputs", {issue_valid_o, busy_o, last_o, lane_en_o, elem_base_o, vl_o}, 64'd0);
        chk("rst_instr", 64'(instr_o), 64'd0);
        chk("rst_read", 64'(buf_read_o), 64'd0);
        @(posedge clk_i);
        @(posedge clk_i);
        #1 rst_i = 1'b0;

        // Op with vl=0: one pop, discarded, no issue.
        pops = 0; ivc = 0;
        push_op(32'h0000_1234, 1'b0);
        for (int k = 0; k < 4; k++) tick();
        chk("vl0_pops", 64'(pops), 64'd1);
        chk("vl0_issue", 64'(ivc), 64'd0);
        chk("vl0_vl", 64'(vl_o), 64'd0);

        // Config 10, op: groups 0/4/8 with 1111/1111/0011.
        pops = 0; ivc = 0;
        push_cfg(10);
        push_op(32'h0000_00A1, 1'b1);
        run_until_idle(30);
        chk("cfg10_vl", 64'(vl_o), 64'd10);
        chk("cfg10_cycles", 64'(ivc), 64'd3);
        chk("cfg10_pops", 64'(pops), 64'd2);

        // Same op with two stall cycles during group 1.
        ivc = 0;
        push_op(32'h0000_00B2, 1'b1);
        tick();
        tick();
        lane_ready_i = 1'b0;
        tick();
        tick();
        chk("stall_base", 64'(elem_base_o), 64'd4);
        chk("stall_instr", 64'(instr_o), 64'h0000_00B2);
        lane_ready_i = 1'b1;
        run_until_idle(30);
        chk("stall_cycles", 64'(ivc), 64'd5);

        // Config 40 saturates to VLMAX; op issues 8 groups.
        ivc = 0;
        push_cfg(40);
        push_op(32'h0000_00C3, 1'b1);
        run_until_idle(40);
        chk("cfg40_vl", 64'(vl_o), 64'd32);
        chk("cfg40_cycles", 64'(ivc), 64'd8);

        // Flush in group 1 with FIFO non-empty.
        push_cfg(10);
        run_until_idle(10);
        ivc = 0;
        push_op(32'h0000_00D4, 1'b1);
        fifo.push_back(32'h0000_00E5);
        refresh();
        tick();
        tick();
        flush_i = 1'b1;
        p0 = pops;
        tick();
        chk("flush_nopop", 64'(pops), 64'(p0));
        chk("flush_idle", 64'(busy_o), 64'd0);
        chk("flush_vl", 64'(vl_o), 64'd10);
        sb.delete();
        // Flush while IDLE only suppresses the pop.
        tick();
        chk("flush_idle_nopop", 64'(pops), 64'(p0));
        chk("flush_idle_vl", 64'(vl_o), 64'd10);
        flush_i = 1'b0;
        ivc = 0;
        begin
            grp_t g;
            for (int b = 0; b < 10; b += 4) begin
                g.base = 6'(b); g.instr = 32'h0000_00E5; g.last = (b + 4) >= 10;
                for (int i = 0; i < 4; i++) g.en[i] = (b + i) < 10;
                sb.push_back(g);
            end
        end
        run_until_idle(30);
        chk("post_flush_cycles", 64'(ivc), 64'd3);
        chk("post_flush_pops", 64'(pops), 64'(p0 + 1));

        // Reset mid-ISSUE.
        push_op(32'h0000_00F6, 1'b1);
        fifo.push_back(32'h0000_0107);
        refresh();
        tick();
        tick();
        chk("pre_rst_busy", 64'(busy_o), 64'd1);
        rst_i = 1'b1;
        #1;
        chk("midrst_outputs", {issue_valid_o, busy_o, last_o, lane_en_o, elem_base_o, vl_o}, 64'd0);
        chk("midrst_instr", 64'(instr_o), 64'd0);
        chk("midrst_read", 64'(buf_read_o), 64'd0);
        sb.delete();
        model_vl = 0;
        p0 = pops; ivc = 0;
        tick();
        tick();
        chk("rst_nopop", 64'(pops), 64'(p0));
        rst_i = 1'b0;
        tick();
        chk("post_rst_pop", 64'(pops), 64'(p0 + 1));
        tick();
        chk("post_rst_noissue", 64'(ivc), 64'd0);
        chk("post_rst_vl", 64'(vl_o), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
